// File: rtl/core_mem_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and data access.
// Define LETC_MEM_ARB_RR_EN to resolve contention round-robin instead of data-first with a starvation limit.
module core_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_rsp_ready,
    output logic [31:0] i_rsp_data,
    input  logic        d_req_valid,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_wen,
    input  logic [31:0] d_req_wdata,
    input  logic [3:0]  d_req_wstrb,
    output logic        d_rsp_ready,
    output logic [31:0] d_rsp_data,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        WAIT_I = 3'd2,
        REQ_D  = 3'd3,
        WAIT_D = 3'd4
    } state_t;

    state_t state, state_next;
    logic   grant_i, grant_d, done_i, done_d, pick_i;

`ifdef LETC_MEM_ARB_RR_EN
    logic last_grant;  // 1 = instruction port won the last grant

    assign pick_i = i_req_valid && (!d_req_valid || !last_grant);

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (grant_i)
            last_grant <= 1'b1;
        else if (grant_d)
            last_grant <= 1'b0;
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    assign pick_i = i_req_valid && (!d_req_valid || starve_cnt == LIMIT);

    // Counts data grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n)
            starve_cnt <= 4'd0;
        else if (grant_i || (state == IDLE && !i_req_valid))
            starve_cnt <= 4'd0;
        else if (grant_d && i_req_valid && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        grant_i       = 1'b0;
        grant_d       = 1'b0;
        done_i        = 1'b0;
        done_d        = 1'b0;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (i_req_valid || d_req_valid) begin
                    if (pick_i) begin
                        grant_i    = 1'b1;
                        state_next = REQ_I;
                    end else begin
                        grant_d    = 1'b1;
                        state_next = REQ_D;
                    end
                end
            end
            REQ_I: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    // A response in the accept cycle completes without visiting WAIT.
                    if (mem_rsp_valid) begin
                        done_i     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_I;
                    end
                end
            end
            WAIT_I: begin
                if (mem_rsp_valid) begin
                    done_i     = 1'b1;
                    state_next = IDLE;
                end
            end
            REQ_D: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    if (mem_rsp_valid) begin
                        done_d     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_D;
                    end
                end
            end
            WAIT_D: begin
                if (mem_rsp_valid) begin
                    done_d     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured at grant so later requester-side changes cannot leak onto the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_rsp_ready   <= 1'b0;
            i_rsp_data    <= 32'h0;
            d_rsp_ready   <= 1'b0;
            d_rsp_data    <= 32'h0;
            mem_req_addr  <= 32'h0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= 32'h0;
            mem_req_wstrb <= 4'b0000;
        end else begin
            i_rsp_ready <= done_i;
            d_rsp_ready <= done_d;
            if (done_i)
                i_rsp_data <= mem_rsp_data;
            if (done_d)
                d_rsp_data <= mem_rsp_data;
            if (grant_i) begin
                mem_req_addr  <= i_req_addr;
                mem_req_wen   <= 1'b0;
                mem_req_wdata <= 32'h0;
                mem_req_wstrb <= 4'b0000;
            end else if (grant_d) begin
                mem_req_addr  <= d_req_addr;
                mem_req_wen   <= d_req_wen;
                mem_req_wdata <= d_req_wdata;
                mem_req_wstrb <= d_req_wstrb;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: requesters and memory model drive, a negedge monitor checks.
module tb_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_rsp_ready;
    logic [31:0] i_rsp_data;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_wen;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_rsp_ready;
    logic [31:0] d_rsp_data;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    always #5 clk = ~clk;

    core_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
        .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wen(d_req_wen),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mreq_t;

    mreq_t       d_src[$];
    mreq_t       exp_req[$];
    logic [31:0] i_src[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    int vectors = 0;
    int miscompares = 0;
    int lat_i = 0;
    int lat_d = 0;
    bit scramble = 1'b0;

    // memory model controls
    int  stall_cfg = 0;
    int  rsp_delay = 1;
    int  stall_cnt = 0;
    int  pend_cnt = 0;
    bit  pending = 1'b0;
    bit  spur_idle = 1'b0;
    bit  spur_stall = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_1013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Memory: ready after stall_cfg cycles of mem_req_valid; response rsp_delay cycles after accept.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
            if (pending) begin
                if (pend_cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(pend_addr);
                    pending = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end else if (mem_req_valid) begin
                if (stall_cnt == stall_cfg) begin
                    stall_cnt = 0;
                    mem_req_ready = 1'b1;
                    if (rsp_delay == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = mem_word(mem_req_addr);
                    end else begin
                        pending   = 1'b1;
                        pend_cnt  = rsp_delay - 1;
                        pend_addr = mem_req_addr;
                    end
                end else begin
                    stall_cnt++;
                    if (spur_stall) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = 32'hBAD0_BAD0;
                    end
                end
            end else if (spur_idle) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // Instruction requester: holds valid until i_rsp_ready, abandons on reset.
    initial begin
        int  n;
        bit  done;
        i_req_valid = 1'b0;
        i_req_addr  = 32'h0;
        forever begin
            @(posedge clk); #1;
            while (i_src.size() > 0 && rst_n) begin
                i_req_valid = 1'b1;
                i_req_addr  = i_src.pop_front();
                n = 0;
                done = 1'b0;
                while (!done) begin
                    @(posedge clk); #1;
                    n++;
                    if (!rst_n) done = 1'b1;
                    else if (i_rsp_ready) begin lat_i = n; done = 1'b1; end
                    else if (n >= 200) begin
                        vectors++; miscompares++;
                        $display("FAIL i_timeout: got no i_rsp_ready expected pulse within 200 cycles");
                        done = 1'b1;
                    end
                end
                i_req_valid = 1'b0;
            end
        end
    end

    // Data requester: same protocol; optionally scrambles its fields after the grant edge.
    initial begin
        int    n;
        bit    done;
        mreq_t r;
        d_req_valid = 1'b0;
        d_req_addr  = 32'h0;
        d_req_wen   = 1'b0;
        d_req_wdata = 32'h0;
        d_req_wstrb = 4'h0;
        forever begin
            @(posedge clk); #1;
            while (d_src.size() > 0 && rst_n) begin
                r = d_src.pop_front();
                d_req_valid = 1'b1;
                d_req_addr  = r.addr;
                d_req_wen   = r.wen;
                d_req_wdata = r.wdata;
                d_req_wstrb = r.wstrb;
                n = 0;
                done = 1'b0;
                while (!done) begin
                    @(posedge clk); #1;
                    n++;
                    if (scramble && n == 1) begin
                        d_req_addr  = ~r.addr;
                        d_req_wen   = ~r.wen;
                        d_req_wdata = ~r.wdata;
                        d_req_wstrb = ~r.wstrb;
                    end
                    if (!rst_n) done = 1'b1;
                    else if (d_rsp_ready) begin lat_d = n; done = 1'b1; end
                    else if (n >= 200) begin
                        vectors++; miscompares++;
                        $display("FAIL d_timeout: got no d_rsp_ready expected pulse within 200 cycles");
                        done = 1'b1;
                    end
                end
                d_req_valid = 1'b0;
            end
        end
    end

    // Monitor: compares every accepted memory request and every completion pulse against the queues.
    mreq_t mon_e;
    always @(negedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            if (exp_req.size() == 0) flag("unexpected_mem_req");
            else begin
                mon_e = exp_req.pop_front();
                check("req_addr", mem_req_addr, mon_e.addr);
                check("req_wen", 32'(mem_req_wen), 32'(mon_e.wen));
                check("req_wstrb", 32'(mem_req_wstrb), 32'(mon_e.wstrb));
                if (mon_e.wen) check("req_wdata", mem_req_wdata, mon_e.wdata);
            end
        end
        if (i_rsp_ready) begin
            if (exp_i.size() == 0) flag("unexpected_i_rsp");
            else check("i_rsp_data", i_rsp_data, exp_i.pop_front());
        end
        if (d_rsp_ready) begin
            if (exp_d.size() == 0) flag("unexpected_d_rsp");
            else check("d_rsp_data", d_rsp_data, exp_d.pop_front());
        end
    end

    function automatic mreq_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                                 input logic [3:0] ws);
        mreq_t m;
        m.addr = a; m.wen = w; m.wdata = wd; m.wstrb = ws;
        return m;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((i_src.size() != 0 || d_src.size() != 0 || exp_req.size() != 0 || exp_i.size() != 0 ||
                exp_d.size() != 0 || i_req_valid || d_req_valid || mem_req_valid || pending) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            vectors++; miscompares++;
            $display("FAIL %s_drain: got busy expected idle within 500 cycles", name);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
        check("rst_rsp_ready", {30'h0, i_rsp_ready, d_rsp_ready}, 32'h0);
        check("rst_i_rsp_data", i_rsp_data, 32'h0);
        check("rst_d_rsp_data", d_rsp_data, 32'h0);
        check("rst_mem_req_addr", mem_req_addr, 32'h0);
        check("rst_mem_req_fields", {27'h0, mem_req_wen, mem_req_wstrb}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // single fetch, response one cycle after accept
        @(negedge clk);
        exp_req.push_back(mk(32'h0000_1000, 1'b0, 32'h0, 4'b0000));
        exp_i.push_back(32'h0000_0013);
        i_src.push_back(32'h0000_1000);
        drain("fetch");
        check("fetch_latency", 32'(lat_i), 32'd3);

        // single data read
        exp_req.push_back(mk(32'h2000_0040, 1'b0, 32'h0, 4'b0000));
        exp_d.push_back(32'h2000_1053);
        d_src.push_back(mk(32'h2000_0040, 1'b0, 32'h0, 4'b0000));
        drain("dread");
        check("dread_latency", 32'(lat_d), 32'd3);

        // stalled write with spurious responses during the stall and scrambled requester fields
        stall_cfg = 5; spur_stall = 1'b1; scramble = 1'b1;
        exp_req.push_back(mk(32'h8000_0004, 1'b1, 32'hCAFE_BABE, 4'b0011));
        exp_d.push_back(32'h8000_1017);
        d_src.push_back(mk(32'h8000_0004, 1'b1, 32'hCAFE_BABE, 4'b0011));
        n = 0;
        @(negedge clk);
        while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 6; k++) begin
            check("stall_addr", mem_req_addr, 32'h8000_0004);
            check("stall_wdata", mem_req_wdata, 32'hCAFE_BABE);
            check("stall_ctl", {26'h0, mem_req_valid, mem_req_wen, mem_req_wstrb}, 32'h0000_0033);
            @(negedge clk);
        end
        drain("stall");
        check("stall_latency", 32'(lat_d), 32'd8);
        stall_cfg = 0; spur_stall = 1'b0; scramble = 1'b0;

        // same-cycle accept and response, then spurious responses while idle
        rsp_delay = 0;
        exp_req.push_back(mk(32'h0000_3000, 1'b0, 32'h0, 4'b0000));
        exp_i.push_back(32'h0000_2013);
        i_src.push_back(32'h0000_3000);
        drain("same_cycle");
        check("same_cycle_latency", 32'(lat_i), 32'd2);
        rsp_delay = 1;
        spur_idle = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("spur_idle_pulses", {30'h0, i_rsp_ready, d_rsp_ready}, 32'h0);
        end
        spur_idle = 1'b0;
        check("spur_idle_i_data", i_rsp_data, 32'h0000_2013);

        // reset while waiting for a data response
        rsp_delay = 4;
        exp_req.push_back(mk(32'h4000_0000, 1'b0, 32'h0, 4'b0000));
        d_src.push_back(mk(32'h4000_0000, 1'b0, 32'h0, 4'b0000));
        n = 0;
        @(negedge clk);
        while (!(mem_req_valid && mem_req_ready) && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_mem_req_valid", 32'(mem_req_valid), 32'h0);
            check("abort_d_rsp_ready", 32'(d_rsp_ready), 32'h0);
        end
        check("abort_d_rsp_data", d_rsp_data, 32'h0);
        rsp_delay = 1;
        drain("abort");

        // contention with both requesters valid throughout
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
`ifdef LETC_MEM_ARB_RR_EN
        exp_req.push_back(mk(32'h0000_2100, 1'b0, 32'h0, 4'h0));
        exp_req.push_back(mk(32'h0000_1100, 1'b0, 32'h0, 4'h0));
        exp_req.push_back(mk(32'h0000_2200, 1'b0, 32'h0, 4'h0));
        exp_req.push_back(mk(32'h0000_1200, 1'b0, 32'h0, 4'h0));
        for (int k = 3; k <= 8; k++) exp_req.push_back(mk(32'h0000_2000 + 32'(k) * 32'h100, 1'b0, 32'h0, 4'h0));
`else
        for (int k = 1; k <= 4; k++) exp_req.push_back(mk(32'h0000_2000 + 32'(k) * 32'h100, 1'b0, 32'h0, 4'h0));
        exp_req.push_back(mk(32'h0000_1100, 1'b0, 32'h0, 4'h0));
        for (int k = 5; k <= 8; k++) exp_req.push_back(mk(32'h0000_2000 + 32'(k) * 32'h100, 1'b0, 32'h0, 4'h0));
        exp_req.push_back(mk(32'h0000_1200, 1'b0, 32'h0, 4'h0));
`endif
        i_src.push_back(32'h0000_1100);
        i_src.push_back(32'h0000_1200);
        exp_i.push_back(mem_word(32'h0000_1100));
        exp_i.push_back(mem_word(32'h0000_1200));
        for (int k = 1; k <= 8; k++) begin
            d_src.push_back(mk(32'h0000_2000 + 32'(k) * 32'h100, 1'b0, 32'h0, 4'h0));
            exp_d.push_back(mem_word(32'h0000_2000 + 32'(k) * 32'h100));
        end
        drain("contention");

        check("left_req", 32'(exp_req.size()), 32'h0);
        check("left_rsp", 32'(exp_i.size() + exp_d.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
